// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: FSM states, response
// bytes and command-byte field positions.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        GET_CSUM,
        EXEC,
        SEND,
        SEND_WAIT
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_HI  = 6;
    localparam int CMD_RSV_LO  = 4;
    localparam int CMD_ADDR_HI = 3;
    localparam int CMD_ADDR_LO = 0;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: counts cycles while enabled, restarts on clear, and
// flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear || !enable)
            count <= '0;
        else if (!expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Register read/write responder driven by received UART bytes.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_error,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic [7:0] err_count
);
    state_t state;
    logic   is_write;
    logic   wait_first;
    logic   expired;
    logic   err_inc;
    logic   rsv_bad;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign rsv_bad = rx_byte[CMD_RSV_HI:CMD_RSV_LO] != 3'b000;

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid),
        .enable  (state == GET_DATA || state == GET_CSUM),
        .expired (expired)
    );

    // Any error cause in a cycle bumps the counter once.
    always_comb begin
        err_inc = 1'b0;
        case (state)
            IDLE:            err_inc = rx_error || (rx_valid && rsv_bad);
            GET_DATA:        err_inc = rx_error || (!rx_valid && expired);
`ifdef UART_CMD_CHECKSUM_EN
            GET_CSUM:        err_inc = rx_error || (rx_valid && rx_byte != csum) || (!rx_valid && expired);
`endif
            EXEC:            err_inc = rx_error || rx_valid;
            SEND, SEND_WAIT: err_inc = rx_valid;
            default:         err_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_byte    <= 8'h00;
            reg_addr   <= 4'h0;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            err_count  <= 8'h00;
            is_write   <= 1'b0;
            wait_first <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            tx_start <= 1'b0;
            reg_we   <= 1'b0;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            case (state)
                IDLE: begin
                    if (!rx_error && rx_valid) begin
                        reg_addr <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
                        is_write <= rx_byte[CMD_WR_BIT];
`ifdef UART_CMD_CHECKSUM_EN
                        csum     <= rx_byte;
`endif
                        if (rsv_bad) begin
                            tx_byte  <= NAK_BYTE;
                            tx_start <= !tx_busy;
                            state    <= SEND;
                        end else if (rx_byte[CMD_WR_BIT]) begin
                            state <= GET_DATA;
                        end else begin
`ifdef UART_CMD_CHECKSUM_EN
                            state <= GET_CSUM;
`else
                            state <= EXEC;
`endif
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_error) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        reg_wdata <= rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
                        csum  <= csum ^ rx_byte;
                        state <= GET_CSUM;
`else
                        reg_we <= 1'b1;
                        state  <= EXEC;
`endif
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                GET_CSUM: begin
                    if (rx_error) begin
                        state <= IDLE;
                    end else if (rx_valid) begin
                        if (rx_byte == csum) begin
                            reg_we <= is_write;
                            state  <= EXEC;
                        end else begin
                            tx_byte  <= NAK_BYTE;
                            tx_start <= !tx_busy;
                            state    <= SEND;
                        end
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
`endif
                // reg_rdata reflects reg_addr from the previous edge here.
                EXEC: begin
                    if (rx_error) begin
                        state <= IDLE;
                    end else begin
                        tx_byte  <= is_write ? ACK_BYTE : reg_rdata;
                        tx_start <= !tx_busy;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_start) begin
                        wait_first <= 1'b1;
                        state      <= SEND_WAIT;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                    end
                end
                SEND_WAIT: begin
                    if (wait_first)
                        wait_first <= 1'b0;
                    else if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized self-checking bench for uart_cmd_responder with a frame-level
// reference model and a simple UART transmitter / register-file model.
module tb_uart_cmd_responder;
    localparam int T = 40;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic [7:0] err_count;

    logic [7:0] periph  [16];
    logic [7:0] exp_mem [16];
    int         exp_err;
    int         n_chk, n_err;
    int         cyc;
    int         last_rx_cyc, lat_ref;
    int         viol_busy, viol_stable;
    logic [7:0] rsp_q[$];
    int         rsp_cyc_q[$];
    logic [11:0] we_q[$];

    assign reg_rdata = periph[reg_addr];

    uart_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_error  (rx_error),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // UART transmitter and register file, observed away from the clock edge.
    initial begin
        int         busy_left;
        logic [7:0] cur_byte;
        tx_busy   = 1'b0;
        busy_left = 0;
        cur_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (reg_we) begin
                we_q.push_back({reg_addr, reg_wdata});
                periph[reg_addr] = reg_wdata;
            end
            if (tx_busy && tx_byte != cur_byte) viol_stable++;
            if (tx_busy) begin
                busy_left--;
                if (busy_left <= 0) tx_busy = 1'b0;
            end
            if (tx_start) begin
                if (tx_busy) viol_busy++;
                rsp_q.push_back(tx_byte);
                rsp_cyc_q.push_back(cyc);
                cur_byte  = tx_byte;
                tx_busy   = 1'b1;
                busy_left = $urandom_range(1, 6);
            end
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_byte     = b;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic pulse_error();
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    // Sends one frame (plus checksum when enabled and the command is well formed).
    task automatic do_frame(input logic [7:0] c, input logic [7:0] d, input bit has_d,
                            input bit junk, input bit bad_k);
        logic [7:0] k;
        k = has_d ? (c ^ d) : c;
        send_byte(c);
        if (has_d) begin
            gap();
            send_byte(d);
        end
`ifdef UART_CMD_CHECKSUM_EN
        if (c[6:4] == 3'b000) begin
            gap();
            if (bad_k) send_byte((k == 8'h00) ? 8'hFF : 8'h00);
            else       send_byte(k);
        end
`else
        if (bad_k) k = ~k;
`endif
        lat_ref = last_rx_cyc;
        if (junk) send_byte(8'($urandom));
    endtask

    task automatic check_txn(input int exp_n, input logic [7:0] exp_b, input bit lat,
                             input bit exp_w, input logic [3:0] wa, input logic [7:0] wd);
        int t;
        t = 0;
        while (rsp_q.size() < exp_n && t < 200) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (tx_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        chk("rsp_count", rsp_q.size(), exp_n);
        if (exp_n > 0 && rsp_q.size() > 0) begin
            chk("rsp_byte", rsp_q[0], exp_b);
            if (lat) chk("latency", rsp_cyc_q[0] - lat_ref, 2);
        end
        chk("we_count", we_q.size(), exp_w ? 1 : 0);
        if (exp_w) begin
            if (we_q.size() > 0) begin
                chk("we_addr", we_q[0][11:8], wa);
                chk("we_data", we_q[0][7:0], wd);
            end
            exp_mem[wa] = wd;
        end
        chk("err_count", err_count, exp_err);
        rsp_q.delete();
        rsp_cyc_q.delete();
        we_q.delete();
    endtask

    int         kind;
    bit         junk;
    logic [3:0] a;
    logic [7:0] d, c;
    logic [2:0] rsv;

    initial begin
        n_chk = 0; n_err = 0; exp_err = 0;
        viol_busy = 0; viol_stable = 0;
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0;
        for (int i = 0; i < 16; i++) begin
            periph[i]  = 8'($urandom);
            exp_mem[i] = periph[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference scenarios
        do_frame(8'h83, 8'h5A, 1, 0, 0);
        check_txn(1, 8'h06, 1, 1, 4'h3, 8'h5A);
        do_frame(8'h03, 8'h00, 0, 0, 0);
        check_txn(1, exp_mem[3], 1, 0, 4'h0, 8'h00);
        chk("read_back_5a", exp_mem[3], 8'h5A);
        do_frame(8'h93, 8'h00, 0, 0, 0);
        exp_err = sat(exp_err);
        check_txn(1, 8'h15, 0, 0, 4'h0, 8'h00);

        send_byte(8'h81);
        repeat (T + 5) @(negedge clk);
        exp_err = sat(exp_err);
        check_txn(0, 8'h00, 0, 0, 4'h0, 8'h00);
        do_frame(8'h01, 8'h00, 0, 0, 0);
        check_txn(1, exp_mem[1], 1, 0, 4'h0, 8'h00);

        send_byte(8'h81);
        pulse_error();
        exp_err = sat(exp_err);
        check_txn(0, 8'h00, 0, 0, 4'h0, 8'h00);

        // Data byte just inside the timeout window is still accepted.
        send_byte(8'h82);
        repeat (T - 4) @(negedge clk);
        send_byte(8'hC3);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h82 ^ 8'hC3);
`endif
        lat_ref = last_rx_cyc;
        check_txn(1, 8'h06, 1, 1, 4'h2, 8'hC3);

`ifdef UART_CMD_CHECKSUM_EN
        do_frame(8'h83, 8'h5A, 1, 0, 1);
        exp_err = sat(exp_err);
        check_txn(1, 8'h15, 0, 0, 4'h0, 8'h00);
`endif

        // Reset in the middle of a write frame discards it.
        send_byte(8'h85);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
        send_byte(8'h77);
        exp_err = sat(exp_err);
        check_txn(1, 8'h15, 0, 0, 4'h0, 8'h00);

        for (int it = 0; it < 80; it++) begin
`ifdef UART_CMD_CHECKSUM_EN
            kind = $urandom_range(0, 7);
`else
            kind = $urandom_range(0, 6);
`endif
            a    = 4'($urandom);
            d    = 8'($urandom);
            junk = ($urandom_range(0, 3) == 0);
            case (kind)
                0, 1: begin
                    c = {4'b1000, a};
                    do_frame(c, d, 1, junk, 0);
                    if (junk) exp_err = sat(exp_err);
                    check_txn(1, 8'h06, 1, 1, a, d);
                end
                2, 3: begin
                    c = {4'b0000, a};
                    do_frame(c, 8'h00, 0, junk, 0);
                    if (junk) exp_err = sat(exp_err);
                    check_txn(1, exp_mem[a], 1, 0, 4'h0, 8'h00);
                end
                4: begin
                    rsv = 3'($urandom_range(1, 7));
                    c = {1'($urandom), rsv, a};
                    do_frame(c, 8'h00, 0, 0, 0);
                    exp_err = sat(exp_err);
                    check_txn(1, 8'h15, 0, 0, 4'h0, 8'h00);
                end
                5: begin
                    send_byte({4'b1000, a});
                    gap();
                    pulse_error();
                    exp_err = sat(exp_err);
                    check_txn(0, 8'h00, 0, 0, 4'h0, 8'h00);
                end
                6: begin
                    send_byte({4'b1000, a});
                    repeat (T + 5) @(negedge clk);
                    exp_err = sat(exp_err);
                    check_txn(0, 8'h00, 0, 0, 4'h0, 8'h00);
                end
                default: begin
                    c = {1'($urandom), 3'b000, a};
                    do_frame(c, d, c[7], junk, 1);
                    exp_err = sat(exp_err);
                    if (junk) exp_err = sat(exp_err);
                    check_txn(1, 8'h15, 0, 0, 4'h0, 8'h00);
                end
            endcase
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            pulse_error();
            exp_err = sat(exp_err);
        end
        check_txn(0, 8'h00, 0, 0, 4'h0, 8'h00);
        chk("err_sat", err_count, 255);

        chk("start_while_busy", viol_busy, 0);
        chk("tx_byte_stable", viol_stable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 120000, max clocks between bytes of one frame before abort.
REQ-002 SHALL have port clk  in  1  master clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_valid  in  1  one-cycle pulse: byte received (UART received).
REQ-005 SHALL have port rx_byte  in  8  received byte, valid with rx_valid.
REQ-006 SHALL have port rx_error  in  1  one-cycle pulse: framing error (UART recv_error).
REQ-007 SHALL have port tx_busy  in  1  UART transmitter busy (UART is_transmitting).
REQ-008 SHALL have port tx_start  out  1  one-cycle transmit request (UART transmit).
REQ-009 SHALL have port tx_byte  out  8  response byte, stable from tx_start until tx_busy falls.
REQ-010 SHALL have port reg_addr  out  4  register address, registered.
REQ-011 SHALL have port reg_wdata  out  8  write data, registered.
REQ-012 SHALL have port reg_we  out  1  one-cycle write strobe.
REQ-013 SHALL have port reg_rdata  in  8  read data, sampled one cycle after reg_addr update.
REQ-014 SHALL have port err_count  out  8  saturating protocol-error counter.

Function
REQ-015 Frame: command byte C; C[7]=1 write, C[7]=0 read; C[3:0]=address; C[6:4] reserved, must be 0.
REQ-016 Write frame = C, D; on completion SHALL pulse reg_we with reg_addr=C[3:0], reg_wdata=D, then send ACK 0x06.
REQ-017 Read frame = C; SHALL drive reg_addr=C[3:0], sample reg_rdata next cycle, send sampled byte.
REQ-018 States: IDLE, GET_DATA, GET_CSUM (macro only), EXEC, SEND, SEND_WAIT.
REQ-019 IDLE->GET_DATA on write C with rx_valid; IDLE->EXEC on read C; reserved bits nonzero -> SEND with NAK 0x15.
REQ-020 GET_DATA->EXEC (or GET_CSUM) on rx_valid; EXEC lasts exactly one cycle, then SEND.
REQ-021 SEND: assert tx_start one cycle when tx_busy=0, then SEND_WAIT; SEND_WAIT ignores first cycle, returns to IDLE when tx_busy=0.
REQ-022 Timeout counter SHALL reset on each accepted byte; reaching TIMEOUT_CYCLES in GET_DATA/GET_CSUM -> IDLE silently, err_count+1.
REQ-023 rx_error in any state except SEND/SEND_WAIT SHALL abort to IDLE, err_count+1, no response.
REQ-024 rx_valid during EXEC/SEND/SEND_WAIT SHALL be dropped, err_count+1.
REQ-025 err_count SHALL saturate at 255; multiple error causes in one cycle count once.
REQ-026 Latency rx_valid of last frame byte -> tx_start SHALL be 2 cycles when tx_busy=0.

Reset
REQ-027 rst_n low SHALL force IDLE, tx_start=0, tx_byte=0, reg_addr=0, reg_wdata=0, reg_we=0, err_count=0, timeout counter=0.
REQ-028 Reset mid-frame or mid-send SHALL discard frame; no reg_we pulse after reset.

Configuration
REQ-029 With UART_CMD_CHECKSUM_EN defined, every frame SHALL end with checksum byte K = XOR of preceding frame bytes (read: K=C; write: K=C^D).
REQ-030 With macro, K mismatch SHALL send NAK 0x15, skip reg_we, err_count+1; without macro, GET_CSUM absent, no checksum byte.

Structure
REQ-031 Package uart_cmd_pkg SHALL hold state enum, ACK_BYTE 0x06, NAK_BYTE 0x15, command field positions.
REQ-032 Sub-module uart_cmd_timeout SHALL implement the inter-byte timeout counter (clear, enable, expired).

Verification
REQ-033 Write 0x83,0x5A -> reg_we one pulse, reg_addr=3, reg_wdata=0x5A; tx_byte=0x06.
REQ-034 Read 0x03 with reg_rdata=0x5A -> tx_start 2 cycles after rx_valid, tx_byte=0x5A.
REQ-035 Command 0x93 -> tx_byte=0x15, no reg_we, err_count=1.
REQ-036 Write 0x81 then no byte for TIMEOUT_CYCLES -> IDLE, no response, err_count=1; next 0x01 read answered.
REQ-037 rx_error after 0x81 -> abort, err_count=1; 256 errors -> err_count=255.
REQ-038 Macro on: 0x83,0x5A,0xD9 -> ACK and write; 0x83,0x5A,0x00 -> NAK, no reg_we.
